// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    HOLD
  } arb_state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int HOLD_TO_DEF = 1024;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter signals of the UART arbiter; slave = arbiter side.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int OWNER_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        ack;
  logic                    tx_start;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_end;
  logic                    busy;
  logic [OWNER_W-1:0]      owner;
  logic                    owner_vld;
  logic                    to_err;

  modport slave (
    input  req, req_data, req_last, tx_busy, tx_end,
    output ack, tx_start, tx_data, busy, owner, owner_vld, to_err
  );

  modport master (
    output req, req_data, req_last, tx_busy, tx_end,
    input  ack, tx_start, tx_data, busy, owner, owner_vld, to_err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above rr_ptr, with wrap.
module uart_rr_pick #(
  parameter int N_REQ   = 4,
  parameter int OWNER_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic [OWNER_W-1:0] gnt_idx,
  output logic               gnt_vld
);

  logic [OWNER_W:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (OWNER_W+1)'(off);
      if (cand >= (OWNER_W+1)'(N_REQ)) begin
        cand = cand - (OWNER_W+1)'(N_REQ);
      end
      if (!gnt_vld && req[cand[OWNER_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART transmitter; req in IDLE -> tx_start after 2 cycles.
// Waits in SEND while tx_busy; locked messages keep ownership through HOLD until timeout.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int HOLD_TO = HOLD_TO_DEF
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam int OWNER_W = $clog2(N_REQ);
  localparam int CNT_W   = $clog2(HOLD_TO);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               owner_vld_q, owner_vld_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               to_err_q, to_err_d;
  logic               busy_q, busy_d;

  logic               gnt_vld;
  logic [OWNER_W-1:0] gnt_idx;
  logic               own_req;
  logic               own_last;
  logic [BYTE_W-1:0]  own_byte;
  logic               release_own;
  logic [OWNER_W-1:0] next_ptr;

  uart_rr_pick #(
    .N_REQ  (N_REQ),
    .OWNER_W(OWNER_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        own_req  = bus.req[i];
        own_last = bus.req_last[i];
        own_byte = bus.req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign next_ptr = (owner_q == OWNER_W'(N_REQ-1)) ? '0 : owner_q + OWNER_W'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    hold_cnt_d  = hold_cnt_q;
    ack_d       = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = '0;
    to_err_d    = 1'b0;
    release_own = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d     = gnt_idx;
          owner_vld_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!own_req) begin
          release_own = 1'b1;
        end else if (!bus.tx_busy) begin
          tx_start_d     = 1'b1;
          tx_data_d      = own_byte;
          ack_d[owner_q] = 1'b1;
          lock_d         = ~own_last;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        // The transmitter cannot finish in the same cycle it is being started.
        if (bus.tx_end && !tx_start_q) begin
          if (lock_q) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else begin
            release_own = 1'b1;
          end
        end
      end
      HOLD: begin
        if (own_req) begin
          state_d = SEND;
        end else if (hold_cnt_q == CNT_W'(HOLD_TO-1)) begin
          to_err_d    = 1'b1;
          release_own = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_own) begin
      state_d     = IDLE;
      owner_d     = '0;
      owner_vld_d = 1'b0;
      rr_ptr_d    = next_ptr;
      lock_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      hold_cnt_q  <= '0;
      ack_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      to_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      hold_cnt_q  <= hold_cnt_d;
      ack_q       <= ack_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      to_err_q    <= to_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = owner_vld_q;
  assign bus.to_err    = to_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: expected bytes/owners queued at stimulus, checked at tx_start.
module tb_uart_tx_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic armed = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int         own;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  uart_tx_arb_if #(.N_REQ(4)) bus ();

  uart_tx_arb #(.N_REQ(4), .HOLD_TO(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic last);
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]        = last;
  endtask

  // Queue the expected byte, wait (bounded) for tx_start, check latency and owner.
  task automatic serve(input int own, input logic [7:0] dat, input int exp_cyc);
    int cyc;
    exp_t e;
    e.own = own;
    e.dat = dat;
    sb.push_back(e);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.tx_start !== 1'b1 && cyc < 40);
    chk("start_seen", {31'b0, bus.tx_start}, 32'd1);
    chk("start_latency", cyc, exp_cyc);
    chk("owner_at_start", {30'b0, bus.owner}, own);
  endtask

  task automatic tx_done(input int d);
    tick();
    chk("start_one_cycle", {31'b0, bus.tx_start}, 32'd0);
    repeat (d - 1) tick();
    bus.tx_end = 1'b1;
    tick();
    bus.tx_end = 1'b0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (bus.tx_start === 1'b1) begin
        chk("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("tx_data", {24'b0, bus.tx_data}, {24'b0, mon_e.dat});
          chk("ack_onehot", {28'b0, bus.ack}, 32'd1 << mon_e.own);
        end
      end else begin
        chk("idle_tx_data", {24'b0, bus.tx_data}, 32'd0);
        chk("idle_ack", {28'b0, bus.ack}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_end   = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_tx_start", {31'b0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("rst_ack", {28'b0, bus.ack}, 32'd0);
    chk("rst_owner_vld", {31'b0, bus.owner_vld}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_to_err", {31'b0, bus.to_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    armed = 1'b1;

    // Single byte from requester 2, tx_end during the start cycle is ignored
    set_byte(2, 8'h41, 1'b1);
    bus.req = 4'b0100;
    sb.push_back('{own: 2, dat: 8'h41});
    tick();
    chk("single_owner_vld", {31'b0, bus.owner_vld}, 32'd1);
    chk("single_owner", {30'b0, bus.owner}, 32'd2);
    chk("single_busy", {31'b0, bus.busy}, 32'd1);
    chk("single_no_early_start", {31'b0, bus.tx_start}, 32'd0);
    tick();
    chk("single_start", {31'b0, bus.tx_start}, 32'd1);
    bus.req    = 4'b0000;
    bus.tx_end = 1'b1;
    tick();
    bus.tx_end = 1'b0;
    chk("tx_end_ignored_busy", {31'b0, bus.busy}, 32'd1);
    chk("tx_end_ignored_vld", {31'b0, bus.owner_vld}, 32'd1);
    bus.tx_end = 1'b1;
    tick();
    bus.tx_end = 1'b0;
    chk("single_release_busy", {31'b0, bus.busy}, 32'd0);
    chk("single_release_vld", {31'b0, bus.owner_vld}, 32'd0);
    chk("single_release_owner", {30'b0, bus.owner}, 32'd0);

    // rr_ptr is now 3: requester 3 beats requester 0
    set_byte(0, 8'hA0, 1'b1);
    set_byte(1, 8'hA1, 1'b1);
    set_byte(2, 8'hA2, 1'b1);
    set_byte(3, 8'hA3, 1'b1);
    bus.req = 4'b1001;
    serve(3, 8'hA3, 2);
    bus.req = 4'b1111;
    tx_done(1);

    // Fairness from rr_ptr 0 with all requesters pending
    for (int k = 0; k < 4; k++) begin
      serve(k, 8'hA0 + 8'(k), 2);
      tx_done(2);
    end
    serve(0, 8'hA0, 2);

    // Locked two-byte message from requester 1 while requester 0 waits
    bus.req = 4'b0011;
    set_byte(0, 8'h30, 1'b1);
    set_byte(1, 8'h48, 1'b0);
    tx_done(2);
    serve(1, 8'h48, 2);
    set_byte(1, 8'h49, 1'b1);
    tx_done(2);
    chk("lock_hold_owner", {30'b0, bus.owner}, 32'd1);
    chk("lock_hold_vld", {31'b0, bus.owner_vld}, 32'd1);
    serve(1, 8'h49, 2);
    bus.req = 4'b0001;
    tx_done(2);
    serve(0, 8'h30, 2);
    bus.req = 4'b0000;
    tx_done(1);

    // Back-pressure: no start while tx_busy is high
    set_byte(2, 8'h5A, 1'b1);
    bus.req     = 4'b0100;
    bus.tx_busy = 1'b1;
    sb.push_back('{own: 2, dat: 8'h5A});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_no_start", {31'b0, bus.tx_start}, 32'd0);
    end
    bus.tx_busy = 1'b0;
    tick();
    chk("bp_start", {31'b0, bus.tx_start}, 32'd1);
    chk("bp_owner", {30'b0, bus.owner}, 32'd2);
    bus.req = 4'b0000;
    tx_done(1);

    // Hold timeout on an abandoned lock from requester 3
    set_byte(3, 8'h7E, 1'b0);
    bus.req = 4'b1000;
    serve(3, 8'h7E, 2);
    bus.req = 4'b0000;
    tx_done(1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk("to_not_yet", {31'b0, bus.to_err}, 32'd0);
        chk("to_hold_vld", {31'b0, bus.owner_vld}, 32'd1);
      end else begin
        chk("to_err_pulse", {31'b0, bus.to_err}, 32'd1);
        chk("to_release_vld", {31'b0, bus.owner_vld}, 32'd0);
        chk("to_release_owner", {30'b0, bus.owner}, 32'd0);
        chk("to_release_busy", {31'b0, bus.busy}, 32'd0);
      end
    end
    tick();
    chk("to_err_one_cycle", {31'b0, bus.to_err}, 32'd0);

    // rr_ptr wrapped to 0 after the timeout release
    set_byte(0, 8'h11, 1'b1);
    set_byte(3, 8'h33, 1'b1);
    bus.req = 4'b1001;
    serve(0, 8'h11, 2);
    bus.req = 4'b0000;
    tx_done(1);

    // Asynchronous reset while waiting for tx_end
    set_byte(2, 8'h66, 1'b1);
    bus.req = 4'b0100;
    serve(2, 8'h66, 2);
    bus.req = 4'b0000;
    tick();
    chk("wait_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx_start", {31'b0, bus.tx_start}, 32'd0);
    chk("arst_owner_vld", {31'b0, bus.owner_vld}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_ack", {28'b0, bus.ack}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.tx_end = 1'b1;
    tick();
    bus.tx_end = 1'b0;
    chk("late_tx_end_busy", {31'b0, bus.busy}, 32'd0);
    chk("late_tx_end_vld", {31'b0, bus.owner_vld}, 32'd0);
    tick();
    chk("late_tx_end_no_start", {31'b0, bus.tx_start}, 32'd0);
    set_byte(0, 8'hC0, 1'b1);
    set_byte(1, 8'hC1, 1'b1);
    set_byte(2, 8'hC2, 1'b1);
    set_byte(3, 8'hC3, 1'b1);
    bus.req = 4'b1111;
    serve(0, 8'hC0, 2);
    bus.req = 4'b0000;
    tx_done(1);

    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
